// File: rtl/integration_sequencer.sv
// Sequences a bank of counters through clear / integrate / freeze / readout windows.
// Optional macro INTEGRATION_OVF_STOP_EN ends the integration window early on any overflow.
module integration_sequencer #(
  parameter int RESOLUTION   = 64,
  parameter int NUM_CHANNELS = 4,
  parameter int CLEAR_CYCLES = 2,
  localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [31:0]                        integration_len,
  input  logic [NUM_CHANNELS*RESOLUTION-1:0] counter_in,
  input  logic [NUM_CHANNELS-1:0]            overflow_in,
  output logic                               counter_reset,
  output logic                               busy,
  output logic [RESOLUTION-1:0]              out_data,
  output logic [CH_W-1:0]                    out_channel,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               overflow_flag,
  output logic                               done
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    INTEGRATE,
    FREEZE,
    READOUT
  } state_t;

  localparam logic [31:0]     CLEAR_LAST = 32'(CLEAR_CYCLES - 1);
  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(NUM_CHANNELS - 1);

  state_t                r_state;
  logic [31:0]           r_count;
  logic [31:0]           r_len;
  logic [CH_W-1:0]       r_chan;
  logic [RESOLUTION-1:0] r_outData;
  logic                  r_outValid;
  logic                  r_done;
  logic                  r_ovf;
  logic                  r_counterReset;
  logic                  r_busy;
  logic [RESOLUTION-1:0] r_shadow [NUM_CHANNELS];

  state_t                w_nextState;
  logic [31:0]           w_nextCount;
  logic [31:0]           w_nextLen;
  logic [CH_W-1:0]       w_nextChan;
  logic [CH_W-1:0]       w_chanInc;
  logic [RESOLUTION-1:0] w_nextData;
  logic                  w_nextValid;
  logic                  w_nextDone;
  logic                  w_nextOvf;
  logic                  w_stopEarly;

`ifdef INTEGRATION_OVF_STOP_EN
  assign w_stopEarly = |overflow_in;
`else
  assign w_stopEarly = 1'b0;
`endif

  assign w_chanInc = r_chan + 1'b1;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextLen   = r_len;
    w_nextChan  = r_chan;
    w_nextData  = r_outData;
    w_nextValid = r_outValid;
    w_nextDone  = 1'b0;
    w_nextOvf   = r_ovf;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nextState = CLEAR;
          w_nextLen   = (integration_len == 32'd0) ? 32'd1 : integration_len;
          w_nextCount = 32'd0;
          w_nextOvf   = 1'b0;
        end
      end
      CLEAR: begin
        if (r_count == CLEAR_LAST) begin
          w_nextState = INTEGRATE;
          w_nextCount = 32'd0;
        end else begin
          w_nextCount = r_count + 32'd1;
        end
      end
      INTEGRATE: begin
        w_nextOvf = r_ovf | (|overflow_in);
        if ((r_count == r_len - 32'd1) || w_stopEarly) begin
          w_nextState = FREEZE;
        end else begin
          w_nextCount = r_count + 32'd1;
        end
      end
      FREEZE: begin
        // Channel 0 goes out straight from the bus; it is captured into the shadow on this same edge.
        w_nextOvf   = r_ovf | (|overflow_in);
        w_nextState = READOUT;
        w_nextChan  = '0;
        w_nextData  = counter_in[RESOLUTION-1:0];
        w_nextValid = 1'b1;
      end
      READOUT: begin
        if (r_outValid && out_ready) begin
          if (r_chan == LAST_CH) begin
            w_nextState = IDLE;
            w_nextValid = 1'b0;
            w_nextDone  = 1'b1;
            w_nextChan  = '0;
          end else begin
            w_nextChan = w_chanInc;
            w_nextData = r_shadow[w_chanInc];
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (abort) begin
      w_nextState = IDLE;
      w_nextValid = 1'b0;
      w_nextDone  = 1'b0;
      w_nextCount = 32'd0;
      w_nextChan  = '0;
    end
  end

  // State and output registers; counter_reset and busy are derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= 32'd0;
      r_len          <= 32'd1;
      r_chan         <= '0;
      r_outData      <= '0;
      r_outValid     <= 1'b0;
      r_done         <= 1'b0;
      r_ovf          <= 1'b0;
      r_counterReset <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_nextState;
      r_count        <= w_nextCount;
      r_len          <= w_nextLen;
      r_chan         <= w_nextChan;
      r_outData      <= w_nextData;
      r_outValid     <= w_nextValid;
      r_done         <= w_nextDone;
      r_ovf          <= w_nextOvf;
      r_counterReset <= (w_nextState != INTEGRATE);
      r_busy         <= (w_nextState != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && r_state == FREEZE) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_shadow[i] <= counter_in[i*RESOLUTION +: RESOLUTION];
      end
    end
  end

  assign counter_reset = r_counterReset;
  assign busy          = r_busy;
  assign out_data      = r_outData;
  assign out_channel   = r_chan;
  assign out_valid     = r_outValid;
  assign overflow_flag = r_ovf;
  assign done          = r_done;

endmodule

// File: tb/tb_integration_sequencer.sv
// Randomized bench for integration_sequencer: each window is judged by its counter_reset
// low-run length, the per-channel readout stream, overflow_flag and the done pulse.
module tb_integration_sequencer;

  localparam int RES = 64;
  localparam int N   = 4;
  localparam int CLR = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           abort;
  logic [31:0]    integration_len;
  logic [N*RES-1:0] counter_in;
  logic [N-1:0]   overflow_in;
  logic           counter_reset;
  logic           busy;
  logic [RES-1:0] out_data;
  logic [1:0]     out_channel;
  logic           out_valid;
  logic           out_ready;
  logic           overflow_flag;
  logic           done;

  int errors = 0;
  int checks = 0;
  logic [63:0] winVals [N];

  integration_sequencer #(
    .RESOLUTION(RES),
    .NUM_CHANNELS(N),
    .CLEAR_CYCLES(CLR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .integration_len(integration_len),
    .counter_in(counter_in),
    .overflow_in(overflow_in),
    .counter_reset(counter_reset),
    .busy(busy),
    .out_data(out_data),
    .out_channel(out_channel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow_flag(overflow_flag),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [31:0] len, input logic a);
    start           = s;
    integration_len = len;
    abort           = a;
  endtask

  task automatic randomCounters();
    for (int i = 0; i < N; i++) counter_in[i*RES +: RES] = {$urandom(), $urandom()};
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".counter_reset"}, 64'(counter_reset), 64'd1);
    checkOutput({tag, ".busy"},          64'(busy),          64'd0);
    checkOutput({tag, ".out_valid"},     64'(out_valid),     64'd0);
    checkOutput({tag, ".out_data"},      64'(out_data),      64'd0);
    checkOutput({tag, ".out_channel"},   64'(out_channel),   64'd0);
    checkOutput({tag, ".overflow_flag"}, 64'(overflow_flag), 64'd0);
    checkOutput({tag, ".done"},          64'(done),          64'd0);
  endtask

  // Runs one full window from an IDLE negedge and leaves the bench at an IDLE negedge.
  task automatic runWindow(input int len, input int ovfIdx, input logic [N-1:0] ovfBits,
                           input int stallChan, input int stallCycles, input bit randReady);
    int lenEff, expLow, hi, lo, k, cyc, stalled;
    bit ready;
    lenEff = (len == 0) ? 1 : len;
    expLow = lenEff;
`ifdef INTEGRATION_OVF_STOP_EN
    if (ovfIdx >= 0 && ovfIdx < lenEff) expLow = ovfIdx + 1;
`endif
    applyStimulus(1'b1, 32'(len), 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("startBusy", 64'(busy), 64'd1);
    checkOutput("startOvfClear", 64'(overflow_flag), 64'd0);

    hi = 0;
    while (counter_reset && hi < 40) begin
      overflow_in = N'($urandom());
      applyStimulus(1'(($urandom() & 1)), $urandom(), 1'b0);
      randomCounters();
      hi++;
      @(negedge clk);
    end
    checkOutput("clearCycles", 64'(hi), 64'(CLR));

    lo = 0;
    while (!counter_reset && lo < lenEff + 40) begin
      overflow_in = (lo == ovfIdx) ? ovfBits : '0;
      applyStimulus(1'(($urandom() & 1)), $urandom(), 1'b0);
      randomCounters();
      lo++;
      @(negedge clk);
    end
    checkOutput("integrateCycles", 64'(lo), 64'(expLow));

    overflow_in = '0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) counter_in[i*RES +: RES] = winVals[i];
    @(negedge clk);

    k = 0;
    cyc = 0;
    stalled = 0;
    while (k < N && cyc < 200) begin
      randomCounters();
      overflow_in = N'($urandom());
      applyStimulus(1'(($urandom() & 1)), $urandom(), 1'b0);
      checkOutput("rdValid", 64'(out_valid), 64'd1);
      checkOutput("rdChannel", 64'(out_channel), 64'(k));
      checkOutput("rdData", 64'(out_data), winVals[k]);
      checkOutput("rdCounterReset", 64'(counter_reset), 64'd1);
      checkOutput("rdNoDone", 64'(done), 64'd0);
      if (k == stallChan && stalled < stallCycles) begin
        ready = 1'b0;
        stalled++;
      end else if (randReady) begin
        ready = ($urandom_range(0, 3) != 0);
      end else begin
        ready = 1'b1;
      end
      out_ready = ready;
      cyc++;
      @(negedge clk);
      if (ready) k++;
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    overflow_in = '0;
    out_ready = 1'b0;
    checkOutput("rdChannelsDone", 64'(k), 64'(N));
    checkOutput("endValid", 64'(out_valid), 64'd0);
    checkOutput("endDone", 64'(done), 64'd1);
    checkOutput("endBusy", 64'(busy), 64'd0);
    checkOutput("endCounterReset", 64'(counter_reset), 64'd1);
    checkOutput("endOvfFlag", 64'(overflow_flag), 64'((ovfIdx >= 0 && ovfIdx < lenEff) ? 1 : 0));
    @(negedge clk);
    checkOutput("donePulseOnce", 64'(done), 64'd0);
    checkOutput("idleBusy", 64'(busy), 64'd0);
  endtask

  initial begin
    int len, lenEff, ovfIdx, lo;
    reset = 1'b1;
    applyStimulus(1'b1, 32'd5, 1'b0);
    counter_in  = '0;
    overflow_in = '1;
    out_ready   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    overflow_in = '0;
    out_ready   = 1'b0;
    checkResetValues("reset");
    @(negedge clk);

    // Nominal window, always ready.
    for (int i = 0; i < N; i++) winVals[i] = {$urandom(), $urandom()};
    runWindow(10, -1, '0, -1, 0, 1'b0);

    // Zero length behaves as one cycle.
    for (int i = 0; i < N; i++) winVals[i] = {$urandom(), $urandom()};
    runWindow(0, -1, '0, -1, 0, 1'b0);

    // Backpressure on channel 2.
    for (int i = 0; i < N; i++) winVals[i] = {$urandom(), $urandom()};
    runWindow(6, -1, '0, 2, 5, 1'b0);

    // Overflow on channel 1 in the fifth integrate cycle of twenty.
    for (int i = 0; i < N; i++) winVals[i] = {$urandom(), $urandom()};
    runWindow(20, 4, 4'b0010, -1, 0, 1'b0);

    // Signed and extreme values captured during freeze.
    winVals[0] = 64'd7;
    winVals[1] = 64'hFFFF_FFFF_FFFF_FFFD;
    winVals[2] = 64'd0;
    winVals[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    runWindow(3, -1, '0, -1, 0, 1'b1);

    // Abort with a simultaneous start during integration.
    applyStimulus(1'b1, 32'd20, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0);
    lo = 0;
    for (int c = 0; c < 40 && lo < 3; c++) begin
      if (!counter_reset) lo++;
      @(negedge clk);
    end
    checkOutput("abortInIntegrate", 64'(counter_reset), 64'd0);
    applyStimulus(1'b1, 32'd5, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("abortBusy", 64'(busy), 64'd0);
    checkOutput("abortCounterReset", 64'(counter_reset), 64'd1);
    checkOutput("abortValid", 64'(out_valid), 64'd0);
    checkOutput("abortDone", 64'(done), 64'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("abortStaysIdle", 64'(busy), 64'd0);
      checkOutput("abortNoDone", 64'(done), 64'd0);
    end

    // Randomized windows.
    for (int w = 0; w < 20; w++) begin
      len    = $urandom_range(0, 15);
      lenEff = (len == 0) ? 1 : len;
      ovfIdx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lenEff - 1) : -1;
      for (int i = 0; i < N; i++) winVals[i] = {$urandom(), $urandom()};
      runWindow(len, ovfIdx, N'(1 << $urandom_range(0, N - 1)),
                $urandom_range(0, N - 1), $urandom_range(0, 4), 1'b1);
    end

    // Reset mid-window beats a simultaneous start.
    applyStimulus(1'b1, 32'd8, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'd8, 1'b1);
    overflow_in = '1;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0);
    overflow_in = '0;
    checkResetValues("midReset");
    @(negedge clk);
    checkOutput("midResetIdle", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
